// File: rtl/padded_window_reader.sv
// padded_window_reader: latches one padded 3-row set per channel
// and streams one 3x3x3 window per column to the conv engine.
module padded_window_reader #(
  parameter int IMG_W = 416,
  parameter int IMG_H = 416,
  parameter int PIX_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       row_valid,
  output logic                       row_ready,
  input  logic [8:0]                 row_idx,
  input  logic [(IMG_W+2)*PIX_W-1:0] R_row0,
  input  logic [(IMG_W+2)*PIX_W-1:0] G_row0,
  input  logic [(IMG_W+2)*PIX_W-1:0] B_row0,
  input  logic [(IMG_W+2)*PIX_W-1:0] R_row1,
  input  logic [(IMG_W+2)*PIX_W-1:0] G_row1,
  input  logic [(IMG_W+2)*PIX_W-1:0] B_row1,
  input  logic [(IMG_W+2)*PIX_W-1:0] R_row2,
  input  logic [(IMG_W+2)*PIX_W-1:0] G_row2,
  input  logic [(IMG_W+2)*PIX_W-1:0] B_row2,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [27*PIX_W-1:0]        win_data,
  output logic [8:0]                 win_col,
  output logic [8:0]                 win_row,
  output logic                       win_last_col,
  output logic                       frame_done
);

  localparam int RW = (IMG_W+2)*PIX_W;
  localparam logic [8:0] LAST_COL = 9'(IMG_W-1);
  localparam logic [8:0] LAST_ROW = 9'(IMG_H-1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t state, state_n;

  logic [RW-1:0] row_in [3][3];
  logic [RW-1:0] sr     [3][3];
  logic          accept;
  logic          advance;
  logic          at_end;

  assign row_in[0][0] = R_row0;
  assign row_in[0][1] = R_row1;
  assign row_in[0][2] = R_row2;
  assign row_in[1][0] = G_row0;
  assign row_in[1][1] = G_row1;
  assign row_in[1][2] = G_row2;
  assign row_in[2][0] = B_row0;
  assign row_in[2][1] = B_row1;
  assign row_in[2][2] = B_row2;

  assign row_ready    = (state == IDLE) && reset;
  assign accept       = row_valid && row_ready;
  assign win_valid    = (state == SCAN);
  assign advance      = win_valid && win_ready;
  assign at_end       = (win_col == LAST_COL);
  assign win_last_col = win_valid && at_end;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // next state: load a row set, then scan until the last column leaves
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept)            state_n = SCAN;
      SCAN: if (advance && at_end) state_n = IDLE;
    endcase
  end

  // window = lowest three pixels of every shift register
  always_comb begin
    win_data = '0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          win_data[(c*9 + r*3 + k)*PIX_W +: PIX_W] =
            sr[c][r][k*PIX_W +: PIX_W];
  end

  // row latch, column shift, and end-of-frame pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          sr[c][r] <= '0;
      win_col    <= '0;
      win_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        for (int c = 0; c < 3; c++)
          for (int r = 0; r < 3; r++)
            sr[c][r] <= row_in[c][r];
        win_col <= '0;
        win_row <= row_idx;
      end else if (advance) begin
        if (at_end) begin
          frame_done <= (win_row == LAST_ROW);
        end else begin
          for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
              sr[c][r] <= sr[c][r] >> PIX_W;
          win_col <= win_col + 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_padded_window_reader.sv
// tb_padded_window_reader: directed checks of the padded window
// reader with IMG_W=4, IMG_H=3, PIX_W=8.
module tb_padded_window_reader;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int PIX_W = 8;
  localparam int RW = (IMG_W+2)*PIX_W;
  localparam int WW = 27*PIX_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          row_valid;
  logic          row_ready;
  logic [8:0]    row_idx;
  logic [RW-1:0] R_row0, G_row0, B_row0;
  logic [RW-1:0] R_row1, G_row1, B_row1;
  logic [RW-1:0] R_row2, G_row2, B_row2;
  logic          win_valid;
  logic          win_ready;
  logic [WW-1:0] win_data;
  logic [8:0]    win_col;
  logic [8:0]    win_row;
  logic          win_last_col;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  // R row1 pixels {0,1,2,3,4,0}, pixel 0 at LSB
  localparam logic [RW-1:0] BASIC = 48'h00_04_03_02_01_00;
  // new set: pads 0, interior all 0xFF
  localparam logic [RW-1:0] ONES  = 48'h00_FF_FF_FF_FF_00;

  // hand-computed R row1 window bytes per column (k=0 at LSB)
  logic [23:0] exp_r1 [4] = '{24'h020100, 24'h030201,
                              24'h040302, 24'h000403};

  padded_window_reader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .reset(reset),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_idx(row_idx),
    .R_row0(R_row0), .G_row0(G_row0), .B_row0(B_row0),
    .R_row1(R_row1), .G_row1(G_row1), .B_row1(B_row1),
    .R_row2(R_row2), .G_row2(G_row2), .B_row2(B_row2),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .win_col(win_col),
    .win_row(win_row), .win_last_col(win_last_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [WW-1:0] obs,
                       input logic [WW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rows(input logic [RW-1:0] v);
    R_row0 = v; G_row0 = v; B_row0 = v;
    R_row1 = v; G_row1 = v; B_row1 = v;
    R_row2 = v; G_row2 = v; B_row2 = v;
  endtask

  task automatic set_basic();
    set_rows('0);
    R_row1 = BASIC;
  endtask

  function automatic logic [WW-1:0] basic_win(input int c);
    logic [WW-1:0] w;
    w = '0;
    w[24 +: 24] = exp_r1[c];
    return w;
  endfunction

  function automatic logic [WW-1:0] ones_win(input logic [23:0] b);
    logic [WW-1:0] w;
    for (int i = 0; i < 9; i++) w[i*24 +: 24] = b;
    return w;
  endfunction

  // present a set while idle; returns in SCAN col0
  task automatic load(input logic [8:0] idx);
    row_idx   = idx;
    row_valid = 1'b1;
    step();
    row_valid = 1'b0;
  endtask

  initial begin
    int hs;
    int col;
    logic rdy_seq [7];
    rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    reset     = 1'b0;
    row_valid = 1'b1;
    row_idx   = '0;
    win_ready = 1'b1;
    set_basic();

    // 1. reset holds everything quiet even with row_valid high
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_row_ready", WW'(row_ready), '0);
      check("rst_win_valid", WW'(win_valid), '0);
      check("rst_win_data", win_data, '0);
      check("rst_frame_done", WW'(frame_done), '0);
    end
    reset     = 1'b1;
    row_valid = 1'b0;
    step();
    check("rst_release_ready", WW'(row_ready), WW'(1));

    // 2. basic row
    load(9'd0);
    for (int c = 0; c < 4; c++) begin
      check("basic_valid", WW'(win_valid), WW'(1));
      check("basic_col", WW'(win_col), WW'(c));
      check("basic_data", win_data, basic_win(c));
      check("basic_last", WW'(win_last_col), WW'(c == 3));
      check("basic_fd", WW'(frame_done), '0);
      step();
    end
    check("basic_end_valid", WW'(win_valid), '0);
    check("basic_end_ready", WW'(row_ready), WW'(1));
    check("basic_end_fd", WW'(frame_done), '0);

    // 3. backpressure 1,0,0,1,1,0,1
    load(9'd0);
    hs  = 0;
    col = 0;
    for (int i = 0; i < 7; i++) begin
      win_ready = rdy_seq[i];
      check("bp_valid", WW'(win_valid), WW'(1));
      check("bp_col", WW'(win_col), WW'(col));
      check("bp_data", win_data, basic_win(col));
      if (win_valid && win_ready) hs++;
      step();
      if (rdy_seq[i]) col++;
    end
    win_ready = 1'b1;
    check("bp_handshakes", WW'(hs), WW'(4));
    check("bp_end_valid", WW'(win_valid), '0);

    // 4. frame end: row 1 silent, row 2 pulses once
    load(9'd1);
    for (int c = 0; c < 4; c++) begin
      check("fe1_fd", WW'(frame_done), '0);
      step();
    end
    check("fe1_end_fd", WW'(frame_done), '0);
    load(9'd2);
    for (int c = 0; c < 4; c++) begin
      check("fe2_row", WW'(win_row), WW'(2));
      check("fe2_fd", WW'(frame_done), '0);
      step();
    end
    check("fe2_pulse", WW'(frame_done), WW'(1));
    step();
    check("fe2_pulse_end", WW'(frame_done), '0);

    // 5. input isolation
    load(9'd0);
    check("iso_c0", win_data, basic_win(0));
    step();
    check("iso_c1", win_data, basic_win(1));
    set_rows(ONES);
    row_idx   = 9'd1;
    row_valid = 1'b1;
    step();
    check("iso_c2", win_data, basic_win(2));
    step();
    check("iso_c3", win_data, basic_win(3));
    step();
    check("iso_idle_ready", WW'(row_ready), WW'(1));
    step();
    row_valid = 1'b0;
    check("iso_new_valid", WW'(win_valid), WW'(1));
    check("iso_new_col", WW'(win_col), '0);
    check("iso_new_row", WW'(win_row), WW'(1));
    check("iso_new_c0", win_data, ones_win(24'hFFFF00));
    step();
    step();
    step();
    check("iso_new_c3", win_data, ones_win(24'h00FFFF));
    step();
    check("iso_new_end", WW'(win_valid), '0);

    // 6. mid-scan reset at col2 of a last-row set
    set_basic();
    load(9'd2);
    step();
    step();
    check("mid_col2", WW'(win_col), WW'(2));
    reset = 1'b0;
    step();
    check("mid_valid", WW'(win_valid), '0);
    check("mid_col", WW'(win_col), '0);
    check("mid_fd", WW'(frame_done), '0);
    check("mid_data", win_data, '0);
    check("mid_ready", WW'(row_ready), '0);
    reset = 1'b1;
    step();
    check("mid_rel_fd", WW'(frame_done), '0);
    check("mid_rel_valid", WW'(win_valid), '0);
    load(9'd0);
    check("mid_new_col", WW'(win_col), '0);
    check("mid_new_data", win_data, basic_win(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
